change_dispenser: RTL

Sequential, inventory-aware change dispenser for the vending datapath. It takes an amount in cents and breaks it into quarter, dime and nickel counts greedily, one coin per cycle. It tracks a per-denomination coin inventory and flags amounts that cannot be paid. It sits between the payment/price subtraction logic and the coin-count display decoders, and replaces the single-cycle fixed-width coin parser.

---
 rtl/change_dispenser.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Greedy quarter/dime/nickel change dispenser, one coin per cycle, with optional
// per-denomination coin inventory enabled by CHANGE_INVENTORY_EN.
module change_dispenser #(
    parameter int unsigned MONEY_W  = 8,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned INV_W    = 6,
    parameter int unsigned INV_INIT = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MONEY_W-1:0] money,
    input  logic               restock,
    output logic               ready,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   Q,
    output logic [CNT_W-1:0]   D,
    output logic [CNT_W-1:0]   N,
    output logic [INV_W-1:0]   inv_q,
    output logic [INV_W-1:0]   inv_d,
    output logic [INV_W-1:0]   inv_n
);

    typedef enum logic [2:0] {StIdle, StCheck, StQtr, StDime, StNick, StDone} state_e;

    localparam logic [MONEY_W-1:0] Cents25 = MONEY_W'(25);
    localparam logic [MONEY_W-1:0] Cents10 = MONEY_W'(10);
    localparam logic [MONEY_W-1:0] Cents5  = MONEY_W'(5);
    localparam logic [CNT_W-1:0]   CntMax  = '1;
    localparam logic [INV_W-1:0]   InvInit = INV_W'(INV_INIT);

    state_e             state;
    logic [MONEY_W-1:0] rem;
    logic [CNT_W-1:0]   qtr_cnt, dime_cnt, nick_cnt;
    logic               bad;
    logic               have_q, have_d, have_n;
    logic               take_q, take_d, take_n;
    logic               rem_odd;

`ifdef CHANGE_INVENTORY_EN
    logic [INV_W-1:0] live_q, live_d, live_n;
    logic [INV_W-1:0] tent_q, tent_d, tent_n;

    assign have_q = (tent_q != '0);
    assign have_d = (tent_d != '0);
    assign have_n = (tent_n != '0);
    assign inv_q  = live_q;
    assign inv_d  = live_d;
    assign inv_n  = live_n;
`else
    logic unused_restock;

    assign unused_restock = restock;
    assign have_q = 1'b1;
    assign have_d = 1'b1;
    assign have_n = 1'b1;
    assign inv_q  = '0;
    assign inv_d  = '0;
    assign inv_n  = '0;
`endif

    assign rem_odd = ((rem % Cents5) != '0);
    assign take_q  = (rem >= Cents25) && have_q && (qtr_cnt != CntMax);
    assign take_d  = (rem >= Cents10) && have_d && (dime_cnt != CntMax);
    assign take_n  = (rem >= Cents5) && have_n && (nick_cnt != CntMax);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= StIdle;
            ready    <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            Q        <= '1;
            D        <= '1;
            N        <= '1;
            rem      <= '0;
            qtr_cnt  <= '0;
            dime_cnt <= '0;
            nick_cnt <= '0;
            bad      <= 1'b0;
`ifdef CHANGE_INVENTORY_EN
            live_q   <= InvInit;
            live_d   <= InvInit;
            live_n   <= InvInit;
            tent_q   <= InvInit;
            tent_d   <= InvInit;
            tent_n   <= InvInit;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
`ifdef CHANGE_INVENTORY_EN
                    if (restock) begin
                        live_q <= InvInit;
                        live_d <= InvInit;
                        live_n <= InvInit;
                    end
`endif
                    if (start) begin
                        rem      <= money;
                        qtr_cnt  <= '0;
                        dime_cnt <= '0;
                        nick_cnt <= '0;
                        err      <= 1'b0;
                        bad      <= 1'b0;
                        ready    <= 1'b0;
                        state    <= StCheck;
`ifdef CHANGE_INVENTORY_EN
                        // A same-cycle restock must be visible to this conversion.
                        tent_q   <= restock ? InvInit : live_q;
                        tent_d   <= restock ? InvInit : live_d;
                        tent_n   <= restock ? InvInit : live_n;
`endif
                    end
                end
                StCheck: begin
                    // Misaligned amounts linger one extra cycle so the error posts two
                    // edges after the accepting edge.
                    if (bad) begin
                        state <= StDone;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        Q     <= '0;
                        D     <= '0;
                        N     <= '0;
                    end else if (rem_odd) begin
                        bad <= 1'b1;
                    end else begin
                        state <= StQtr;
                    end
                end
                StQtr: begin
                    if (take_q) begin
                        rem     <= rem - Cents25;
                        qtr_cnt <= qtr_cnt + CNT_W'(1);
`ifdef CHANGE_INVENTORY_EN
                        tent_q  <= tent_q - INV_W'(1);
`endif
                    end else begin
                        state <= StDime;
                    end
                end
                StDime: begin
                    if (take_d) begin
                        rem      <= rem - Cents10;
                        dime_cnt <= dime_cnt + CNT_W'(1);
`ifdef CHANGE_INVENTORY_EN
                        tent_d   <= tent_d - INV_W'(1);
`endif
                    end else begin
                        state <= StNick;
                    end
                end
                StNick: begin
                    if (take_n) begin
                        rem      <= rem - Cents5;
                        nick_cnt <= nick_cnt + CNT_W'(1);
`ifdef CHANGE_INVENTORY_EN
                        tent_n   <= tent_n - INV_W'(1);
`endif
                    end else begin
                        state <= StDone;
                        done  <= 1'b1;
                        if (rem == '0) begin
                            err    <= 1'b0;
                            Q      <= qtr_cnt;
                            D      <= dime_cnt;
                            N      <= nick_cnt;
`ifdef CHANGE_INVENTORY_EN
                            live_q <= tent_q;
                            live_d <= tent_d;
                            live_n <= tent_n;
`endif
                        end else begin
                            // Shortfall: nothing is paid out, inventory stays put.
                            err <= 1'b1;
                            Q   <= '0;
                            D   <= '0;
                            N   <= '0;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    ready <= 1'b1;
                end
                default: begin
                    state <= StIdle;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
